// File: rtl/rotating_square_gen_pkg.sv
// Shared constants and types for the rotating-square animator.
package rot_sq_pkg;

  localparam logic [7:0] SSEG_UPPER = 8'h9C;
  localparam logic [7:0] SSEG_LOWER = 8'hA3;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  typedef enum logic {
    MODE_CIRC   = 1'b0,
    MODE_BOUNCE = 1'b1
  } mode_e;

endpackage

// File: rtl/rotating_square_gen_tick_gen.sv
// Programmable-period clock-enable: one tick every 'period' enabled cycles.
module tick_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tick
);

  logic [W-1:0] count;
  logic         due;

  // >= rather than == so a shortened period never strands the count above it
  assign due  = (count >= (period - W'(1)));
  assign tick = en && !rst && due;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      if (due) count <= '0;
      else     count <= count + W'(1);
    end
  end

endmodule

// File: rtl/rotating_square_gen.sv
// Rotating-square animator for an N-digit multiplexed, active-low 7-segment display.
module rotating_square_gen
  import rot_sq_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100_000,
  parameter int STEP_DIV    = 25_000_000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            cw,
  input  logic                            mode,
  input  logic [1:0]                      speed,
  output logic [N_DIGITS-1:0]             an,
  output logic [7:0]                      sseg,
  output logic [$clog2(2*N_DIGITS)-1:0]   pos,
  output logic                            step
);

  localparam int P  = 2 * N_DIGITS;
  localparam int PW = $clog2(P);
  localparam int DW = $clog2(N_DIGITS);
  localparam int SW = $clog2(STEP_DIV + 1);
  localparam int RW = $clog2(REFRESH_DIV + 1);

  localparam logic [PW-1:0] POS_LAST       = PW'(P - 1);
  localparam logic [PW-1:0] POS_N          = PW'(N_DIGITS);
  localparam logic [DW-1:0] DIG_LAST       = DW'(N_DIGITS - 1);
  localparam logic [SW-1:0] STEP_BASE      = SW'(STEP_DIV);
  localparam logic [RW-1:0] REFRESH_PERIOD = RW'(REFRESH_DIV);

  mode_e                mode_cur;
  logic                 mode_q;
  logic                 dir;
  logic                 dir_eff;
  logic                 dir_next;
  logic [PW-1:0]        pos_next;
  logic [DW-1:0]        digit;
  logic [SW-1:0]        step_period;
  logic                 refresh_tick;
  logic [PW-1:0]        target;
  logic [7:0]           shape;
  logic [N_DIGITS-1:0]  an_next;
  logic [7:0]           sseg_next;

  assign mode_cur    = mode_e'(mode);
  assign step_period = STEP_BASE >> speed;

  tick_gen #(.W(SW)) u_step_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .period (step_period),
    .tick   (step)
  );

  tick_gen #(.W(RW)) u_refresh_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .period (REFRESH_PERIOD),
    .tick   (refresh_tick)
  );

  // mode_q reloads from mode during reset so leaving reset is never seen as a mode rise
  always_ff @(posedge clk) begin
    if (rst) begin
      pos    <= '0;
      dir    <= 1'b1;
      mode_q <= mode;
      digit  <= '0;
    end else begin
      pos    <= pos_next;
      dir    <= dir_next;
      mode_q <= mode;
      if (refresh_tick) digit <= (digit == DIG_LAST) ? '0 : digit + DW'(1);
    end
  end

  // A mode rise loads cw into the direction before any coincident step uses it
  always_comb begin
    dir_eff  = (mode_cur == MODE_BOUNCE && !mode_q) ? cw : dir;
    dir_next = dir_eff;
    pos_next = pos;
    if (step) begin
      if (mode_cur == MODE_CIRC) begin
        if (cw) pos_next = (pos == POS_LAST) ? '0 : pos + PW'(1);
        else    pos_next = (pos == '0) ? POS_LAST : pos - PW'(1);
      end else if (dir_eff) begin
        if (pos == POS_LAST) begin
          pos_next = POS_LAST - PW'(1);
          dir_next = 1'b0;
        end else begin
          pos_next = pos + PW'(1);
        end
      end else begin
        if (pos == '0) begin
          pos_next = PW'(1);
          dir_next = 1'b1;
        end else begin
          pos_next = pos - PW'(1);
        end
      end
    end
  end

  always_comb begin
    if (pos < POS_N) begin
      target = POS_N - PW'(1) - pos;
      shape  = SSEG_UPPER;
    end else begin
      target = pos - POS_N;
      shape  = SSEG_LOWER;
    end
    an_next        = '1;
    an_next[digit] = 1'b0;
    sseg_next      = (PW'(digit) == target) ? shape : SSEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an   <= '1;
      sseg <= SSEG_BLANK;
    end else begin
      an   <= an_next;
      sseg <= sseg_next;
    end
  end

endmodule
